fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0100_0000: PC loaded at reset.
REQ-002 SHALL have parameter RETRY_LIMIT, default 2: retries per fetch when FETCH_RETRY_EN is defined.
REQ-003 SHALL have clk  in  1: single clock; all state changes on posedge.
REQ-004 SHALL have rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have start  in  1: level; leaves IDLE while high.
REQ-006 SHALL have redirect  in  1, redirect_pc  in  32: branch/jump target load.
REQ-007 SHALL have imem_fetch  out  1, imem_addr  out  32: request to IMEM (instrfetch/addr_imem).
REQ-008 SHALL have imem_instr  in  32, imem_fetched  in  1: IMEM registered response, one cycle after request.
REQ-009 SHALL have instr_out  out  32, pc_out  out  32, instr_valid  out  1, instr_ready  in  1: valid/ready output to decode.
REQ-010 SHALL have fault  out  1, fault_pc  out  32: sticky fetch fault and faulting PC.

Function
REQ-011 SHALL implement states IDLE, FETCH, WAIT, VALID, FAULT; imem_addr SHALL equal the internal pc register at all times.
REQ-012 IDLE: start=1 -> FETCH; else stay.
REQ-013 FETCH: pc[1:0]!=0 -> FAULT, imem_fetch=0; else imem_fetch=1 for exactly this cycle -> WAIT.
REQ-014 WAIT: imem_fetch=0; imem_fetched=1 -> capture instr_out<=imem_instr, pc_out<=pc -> VALID; imem_fetched=0 -> retry/fault per REQ-025/026.
REQ-015 VALID: instr_valid=1; instr_out, pc_out stable until instr_ready=1; on handshake pc<=pc+4 (mod 2^32) -> FETCH; no imem_fetch issued while VALID.
REQ-016 Minimum issue interval SHALL be 3 cycles (FETCH, WAIT, VALID); load-to-valid latency 2 cycles after FETCH entry.
REQ-017 redirect SHALL take priority over all other transitions: pc<=redirect_pc.
REQ-018 redirect in FETCH: imem_fetch forced 0 that cycle (combinational), stay FETCH.
REQ-019 redirect in WAIT: response discarded, no capture, -> FETCH.
REQ-020 redirect in VALID (with or without instr_ready): instr_valid=0 next cycle, -> FETCH; next pc is redirect_pc, never pc+4.
REQ-021 redirect in IDLE: pc loaded, stay IDLE. redirect in FAULT: fault<=0, retry count cleared, -> FETCH.
REQ-022 Entering FAULT: fault<=1, fault_pc<=pc, instr_valid=0; FAULT exits only by redirect or reset; start ignored.
REQ-023 start deasserted outside IDLE SHALL NOT abort an in-flight fetch.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, pc=RESET_PC (so imem_addr=RESET_PC), imem_fetch=0, instr_out=0, pc_out=0, instr_valid=0, fault=0, fault_pc=0, retry count=0; any in-flight response after release is ignored.

Configuration
REQ-025 With FETCH_RETRY_EN defined: imem_fetched=0 in WAIT with retry count<RETRY_LIMIT -> count+1, -> FETCH same pc; count=RETRY_LIMIT -> FAULT; count cleared on every successful capture and redirect.
REQ-026 Without FETCH_RETRY_EN: imem_fetched=0 in WAIT -> FAULT immediately; no retry counter synthesized.

Verification
REQ-027 Reset release, start=1, instr_ready=1, IMEM[0]=32'h00500093 -> imem_fetch pulse with imem_addr=32'h0100_0000, instr_valid two cycles later with instr_out=32'h00500093, pc_out=32'h0100_0000; next fetch addr 32'h0100_0004.
REQ-028 instr_ready=0 for 5 cycles in VALID -> instr_valid=1, instr_out/pc_out unchanged, imem_fetch=0 all 5 cycles; handshake then advances pc by 4.
REQ-029 redirect=1, redirect_pc=32'h0100_0100 during WAIT -> pending response never appears on instr_out; next imem_fetch addr 32'h0100_0100; valid data=IMEM[64].
REQ-030 redirect_pc=32'h0200_0000 (outside IMEM window) -> with FETCH_RETRY_EN 3 imem_fetch pulses then fault=1, fault_pc=32'h0200_0000; without, 1 pulse then fault.
REQ-031 redirect_pc=32'h0100_0002 -> fault=1 with zero imem_fetch pulses; later redirect to 32'h0100_0000 clears fault and fetches IMEM[0].
REQ-032 rst_n asserted mid-VALID, asynchronously to clk -> instr_valid, fault, imem_fetch drop to 0 and imem_addr=32'h0100_0000 before the next clk edge.

Source files
------------

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - IMEM request/response and decode valid/ready bundle for fetch_ctrl
interface fetch_if;
    logic        imem_fetch;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_fetched;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_fetch, imem_addr, instr_out, pc_out, instr_valid,
        input  imem_instr, imem_fetched, instr_ready
    );

    modport slave (
        input  imem_fetch, imem_addr, instr_out, pc_out, instr_valid,
        output imem_instr, imem_fetched, instr_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch FSM with redirect, sticky fault, optional retry (FETCH_RETRY_EN)
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0100_0000,
    parameter int          RETRY_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    fetch_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_FAULT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        capture;
    logic        set_fault;
    logic        clr_fault;
    logic        fetch_req;

`ifdef FETCH_RETRY_EN
    localparam int RETRY_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(RETRY_LIMIT);

    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_inc;
    logic               retry_clr;
`endif

    // Next-state and request decode; redirect outranks every other transition.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        set_fault = 1'b0;
        clr_fault = 1'b0;
        fetch_req = 1'b0;
`ifdef FETCH_RETRY_EN
        retry_inc = 1'b0;
        retry_clr = redirect;
`endif
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end else if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end else if (pc[1:0] != 2'b00) begin
                    set_fault = 1'b1;
                    state_nxt = S_FAULT;
                end else begin
                    fetch_req = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_FETCH;
                end else if (bus.imem_fetched) begin
                    capture   = 1'b1;
                    state_nxt = S_VALID;
`ifdef FETCH_RETRY_EN
                    retry_clr = 1'b1;
                end else if (retry_cnt < RETRY_MAX) begin
                    retry_inc = 1'b1;
                    state_nxt = S_FETCH;
`endif
                end else begin
                    set_fault = 1'b1;
                    state_nxt = S_FAULT;
                end
            end
            S_VALID: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_FETCH;
                end else if (bus.instr_ready) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_FETCH;
                end
            end
            S_FAULT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    clr_fault = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.imem_fetch  = fetch_req;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state == S_VALID);

    // State, pc and captured instruction/fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            bus.instr_out <= 32'd0;
            bus.pc_out    <= 32'd0;
            fault         <= 1'b0;
            fault_pc      <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                bus.instr_out <= bus.imem_instr;
                bus.pc_out    <= pc;
            end
            if (set_fault) begin
                fault    <= 1'b1;
                fault_pc <= pc;
            end else if (clr_fault) begin
                fault <= 1'b0;
            end
        end
    end

`ifdef FETCH_RETRY_EN
    // Retry counter: cleared by a good capture or any redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (retry_clr) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end
`endif

endmodule
